// File: rtl/mul_operand_feeder_pkg.sv
// Shared definitions for the multiplier operand feeder: FSM state encoding
// and the default operand/bus width.
package mul_operand_feeder_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_LOAD_A    = 3'd2,
        ST_LOAD_B    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RETIRE    = 3'd5,
        ST_WAIT_CLR  = 3'd6,
        ST_ERR       = 3'd7
    } state_e;

endpackage

// File: rtl/mul_operand_feeder_op_pair_fifo.sv
// Small synchronous FIFO holding {A,B} operand pairs; the head is visible
// combinationally so the controller can inspect it in the same cycle.
module op_pair_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Buffers operand pairs and sequences them onto the repeated-addition
// multiplier's load bus, bypassing zero operands and watching for a hung multiplier.
module mul_operand_feeder
    import mul_operand_feeder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             start,
    output logic [WIDTH-1:0] data_in,
    input  logic             done,
    output logic             op_ack,
    output logic             zero_byp,
    output logic             timeout_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               byp_q, byp_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    op_pair_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_a      = head[2*WIDTH-1:WIDTH];
    assign head_b      = head[WIDTH-1:0];
    assign in_ready    = !fifo_full;
    assign timeout_err = (state_q == ST_ERR);
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byp_d    = byp_q;
        fifo_pop = 1'b0;
        start    = 1'b0;
        data_in  = '0;
        op_ack   = 1'b0;
        zero_byp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    // A zero operand makes the product trivially 0; never start the multiplier.
                    if ((head_a == '0) || (head_b == '0)) begin
                        byp_d   = 1'b1;
                        state_d = ST_RETIRE;
                    end else if (!done) begin
                        byp_d   = 1'b0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                start   = 1'b1;
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                data_in = head_a;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                data_in = head_b;
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                data_in = head_b;
                if (done) begin
                    state_d = ST_RETIRE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RETIRE: begin
                op_ack   = 1'b1;
                zero_byp = byp_q;
                fifo_pop = 1'b1;
                state_d  = byp_q ? ST_IDLE : ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // done is sticky until the multiplier is re-initialised externally.
                if (!done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byp_q   <= byp_d;
        end
    end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Scoreboard bench: a driver queues expected retirements, a negedge monitor
// models the multiplier (done generation) and checks bus activity and acks.
module tb_mul_operand_feeder;

    localparam int W        = 16;
    localparam int D        = 2;
    localparam int TO       = 16;
    localparam int DONE_DLY = 4;

    localparam int P_IDLE = 0;
    localparam int P_LA   = 1;
    localparam int P_LB   = 2;
    localparam int P_WD   = 3;
    localparam int P_RT   = 4;
    localparam int P_CLR  = 5;
    localparam int P_ERR  = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic         start;
    logic [W-1:0] data_in;
    logic         done = 1'b0;
    logic         op_ack;
    logic         zero_byp;
    logic         timeout_err;
    logic         busy;

    mul_operand_feeder #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .start       (start),
        .data_in     (data_in),
        .done        (done),
        .op_ack      (op_ack),
        .zero_byp    (zero_byp),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           zero;
        int           ack_cyc;
        int           start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int phase = P_IDLE;
    int ph0;
    int dcnt = 0;
    int clr_cnt = 0;
    int n_start = 0;
    int n_ack = 0;
    bit mdone = 1'b0;
    bit hold_done = 1'b0;
    bit never_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor + multiplier model: phase is the expected feeder state for the current cycle.
    always @(negedge clk) begin
        if (rst) begin
            phase = P_IDLE;
            mdone = 1'b0;
            done  = hold_done;
        end else begin
            ph0 = phase;
            chk("in_ready", in_ready, exp_q.size() < D);
            if (start) n_start++;
            case (phase)
                P_IDLE: begin
                    chk("idle_data", data_in, 0);
                    chk("no_timeout", timeout_err, 0);
                    if (start) begin
                        chk("done_low_at_start", done, 0);
                        if (exp_q.size() == 0) begin
                            chk("start_without_pair", 1, 0);
                        end else begin
                            chk("start_on_zero_pair", exp_q[0].zero, 0);
                            if (exp_q[0].start_cyc >= 0)
                                chk("start_latency", cyc, exp_q[0].start_cyc);
                        end
                        phase = P_LA;
                    end
                end
                P_LA: begin
                    chk("load_a_no_start", start, 0);
                    if (exp_q.size() > 0) chk("load_a_data", data_in, exp_q[0].a);
                    phase = P_LB;
                end
                P_LB: begin
                    if (exp_q.size() > 0) chk("load_b_data", data_in, exp_q[0].b);
                    dcnt  = 0;
                    phase = P_WD;
                end
                P_WD: begin
                    dcnt++;
                    if (never_done && dcnt == TO + 1) begin
                        chk("timeout_rise", timeout_err, 1);
                        phase = P_ERR;
                    end else begin
                        if (exp_q.size() > 0) chk("wait_data", data_in, exp_q[0].b);
                        chk("wait_busy", busy, 1);
                        if (never_done && dcnt == TO) chk("timeout_early", timeout_err, 0);
                        if (!never_done && dcnt == DONE_DLY) begin
                            mdone = 1'b1;
                            phase = P_RT;
                        end
                    end
                end
                P_RT: begin
                    chk("retire_ack", op_ack, 1);
                    chk("retire_data", data_in, 0);
                    clr_cnt = $urandom_range(0, 3);
                    phase   = P_CLR;
                end
                P_CLR: begin
                    chk("clr_data", data_in, 0);
                    chk("clr_no_start", start, 0);
                    if (clr_cnt == 0) begin
                        mdone = 1'b0;
                        phase = P_IDLE;
                    end else begin
                        clr_cnt--;
                    end
                end
                P_ERR: begin
                    chk("timeout_sticky", timeout_err, 1);
                    chk("err_no_start", start, 0);
                end
                default: ;
            endcase
            if (op_ack) begin
                n_ack++;
                if (exp_q.size() == 0) begin
                    chk("ack_without_pair", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("zero_byp", zero_byp, e.zero);
                    chk("ack_phase", ph0, e.zero ? P_IDLE : P_RT);
                    if (e.ack_cyc >= 0) chk("ack_latency", cyc, e.ack_cyc);
                end
            end
            done = mdone | hold_done;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit timed,
                        output int stalls);
        bit   acc = 1'b0;
        int   n = 0;
        int   hc = 0;
        exp_t x;
        stalls = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            acc      = in_ready;
            hc       = cyc;
            if (!acc) stalls++;
            @(posedge clk);
            n++;
        end
        #1 in_valid = 1'b0;
        if (acc) begin
            x.a         = a;
            x.b         = b;
            x.zero      = (a == '0) || (b == '0);
            x.ack_cyc   = (timed && x.zero) ? hc + 2 : -1;
            x.start_cyc = (timed && !x.zero) ? hc + 2 : -1;
            exp_q.push_back(x);
        end else begin
            chk("send_accept", 0, 1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || phase != P_IDLE || done) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_phase(input int p, input string name);
        int n = 0;
        while (phase != p && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, phase, p);
    endtask

    initial begin
        int st;
        int s0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_op_ack", op_ack, 0);
        chk("rst_zero_byp", zero_byp, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        s0 = n_start;
        send(16'd5, 16'd3, 1'b1, st);
        wait_drain();
        chk("single_start_count", n_start - s0, 1);
        chk("single_ack_count", n_ack, 1);

        send(16'd7, 16'd2, 1'b0, st);
        send(16'd9, 16'd4, 1'b0, st);
        send(16'd11, 16'd6, 1'b0, st);
        chk("third_stalled", st > 0, 1);
        wait_drain();

        s0 = n_start;
        send(16'd0, 16'd8, 1'b1, st);
        wait_drain();
        chk("bypass_no_start", n_start - s0, 0);

        hold_done = 1'b1;
        @(negedge clk);
        #1;
        s0 = n_start;
        send(16'd6, 16'd6, 1'b0, st);
        repeat (10) @(negedge clk);
        #1;
        chk("held_no_start", n_start - s0, 0);
        chk("held_idle", busy, 0);
        hold_done = 1'b0;
        wait_drain();
        chk("held_start_after_drop", n_start - s0, 1);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            send(ra, rb, 1'b0, st);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

        send(16'd3, 16'd4, 1'b0, st);
        send(16'd5, 16'd6, 1'b0, st);
        wait_phase(P_WD, "reach_load_b");
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_data_in", data_in, 0);
        chk("midrst_start", start, 0);
        #1 rst = 1'b0;
        s0 = n_ack;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_discarded", n_ack - s0, 0);
        chk("midrst_idle", busy, 0);

        never_done = 1'b1;
        send(16'd2, 16'd3, 1'b0, st);
        wait_phase(P_ERR, "reach_err");
        repeat (5) @(negedge clk);
        send(16'd1, 16'd1, 1'b0, st);
        @(negedge clk);
        #1;
        chk("err_queue_full", in_ready, 0);
        chk("err_timeout", timeout_err, 1);
        rst = 1'b1;
        exp_q.delete();
        never_done = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("err_cleared", timeout_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_operand_feeder.md
Name: mul_operand_feeder

Overview:
- Upstream stage of the repeated-addition multiplier.
- Accepts operand pairs (A, B) over a valid/ready handshake and buffers them in a 2-entry queue.
- Sequences each pair onto the multiplier's shared 16-bit load bus and pulses its start input.
- Waits for done, retires the pair, and bypasses the multiplier for zero operands. A watchdog flags a multiplier that never finishes.

Parameters:
- WIDTH, 16, operand and bus width.
- DEPTH, 2, operand queue entries (power of two).
- TIMEOUT, 1024, cycles allowed from start to done before error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier (loop count)
- in_ready  output  1  queue not full
- start  output  1  one-cycle pulse to multiplier controller
- data_in  output  WIDTH  multiplier load bus
- done  input  1  multiplier controller done (level, sticky)
- op_ack  output  1  one-cycle pulse: current pair retired
- zero_byp  output  1  valid with op_ack: pair bypassed, product is 0
- timeout_err  output  1  sticky watchdog error
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: queue empty, FSM to IDLE, and all outputs 0 (in_ready=1 once reset is released). data_in=0 and timeout_err=0.
- Reset mid-operation abandons the pair in flight and empties the queue.
- Enqueue:
  - A pair is written when in_valid && in_ready.
  - in_ready = !full, registered from the pointer state.
  - The same-cycle dequeue does not free space until the next cycle.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT_DONE, RETIRE, WAIT_CLR, ERR.
- IDLE:
  - If the queue is not empty and the head has A==0 or B==0, go to RETIRE with zero_byp=1. The multiplier is not started.
  - Otherwise, if the queue is not empty and done==0, go to START.
- START (1 cycle): start=1, data_in=0.
- LOAD_A (1 cycle): data_in=head A. The multiplier loads A at the end of this cycle.
- LOAD_B (1 cycle): data_in=head B. The multiplier loads B and clears P at the end of this cycle.
- WAIT_DONE:
  - data_in holds head B.
  - The watchdog counter increments each cycle.
  - done==1 goes to RETIRE.
  - Counter reaching TIMEOUT-1 goes to ERR.
- RETIRE (1 cycle):
  - op_ack=1, zero_byp as decided, head popped.
  - Next state is WAIT_CLR if the multiplier was used, IDLE if bypassed.
- WAIT_CLR:
  - Hold until done==0; the multiplier must be re-initialised externally.
  - Then go to IDLE.
  - No new start may be issued while done==1.
- ERR:
  - timeout_err=1 (sticky), start is never asserted, the queue keeps accepting until full.
  - Only rst leaves ERR.
- Latency: non-zero pair enqueued into an empty queue while idle gives start 2 cycles after the handshake cycle. A bypassed pair gives op_ack 2 cycles after the handshake.
- data_in is 0 in every state except LOAD_A, LOAD_B and WAIT_DONE.
- Queue pointers are log2(DEPTH)+1 bits wide. They wrap modulo DEPTH, and the extra MSB distinguishes full from empty.
- Widths: no arithmetic on operands; watchdog counter is clog2(TIMEOUT) bits and saturates.

Decomposition:
- Shared package: FSM state encoding constants (3-bit), default WIDTH.
- One sub-module, op_pair_fifo: synchronous 2*WIDTH-wide FIFO with push/pop/full/empty.
- The FSM and watchdog stay in mul_operand_feeder.

Test Plan:
- Single pair A=5, B=3, with a multiplier model asserting done 4 cycles after LOAD_B:
  - start pulses once.
  - data_in=5 in LOAD_A, then 3 in LOAD_B.
  - op_ack once, zero_byp=0.
- Back-to-back pairs (7,2), (9,4) plus a third offered while full:
  - in_ready=0 on the third until the first retires.
  - Second start is not issued until done returns low.
- Pair (0,8): no start, op_ack with zero_byp=1 two cycles after the handshake, data_in stays 0.
- Model that never asserts done, with TIMEOUT=16: timeout_err rises 16 cycles after entering WAIT_DONE and stays high. start is never reasserted.
- rst asserted during LOAD_B: next cycle busy=0, in_ready=1, data_in=0, and queued pairs are discarded.
- done held high from reset with a pair queued: FSM stays in IDLE, no start until done drops.
